// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch front end.
// Owns the PC, runs a req/ack fetch to a variable-latency instruction
// memory, evaluates RV64I branch conditions, defers PC loads that arrive
// while a fetch is outstanding, and rejects misaligned PC targets.
module pc_fetch_unit #(
   parameter int unsigned          XLEN        = 64,
   parameter logic [XLEN-1:0]      RESET_PC    = '0,
   parameter int unsigned          ALIGN_CHECK = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_start,
   output logic            imem_req,
   output logic [31:0]     imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   output logic            ir_valid,
   output logic            busy,
   output logic [XLEN-1:0] pc,
   input  logic            pc_write,
   input  logic            br_en,
   input  logic [2:0]      br_cond,
   input  logic [XLEN-1:0] br_a,
   input  logic [XLEN-1:0] br_b,
   input  logic [XLEN-1:0] pc_in,
   output logic            misalign
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_pend;
   logic              r_pend_v;
   logic [31:0]       r_addr;
   logic [31:0]       r_ir;
   logic              r_ir_valid;
   logic              r_misalign;

   logic              w_cond;
   logic              w_take;
   logic              w_ld;
   logic              w_bad_tgt;
   logic              w_ld_ok;
   logic              w_accept;
   logic              w_ack_take;

   // Branch condition decode on funct3; 010/011 are not branch encodings.
   always_comb begin
      w_cond = 1'b0;
      case (br_cond)
         3'b000:  w_cond = (br_a == br_b);
         3'b001:  w_cond = (br_a != br_b);
         3'b100:  w_cond = ($signed(br_a) <  $signed(br_b));
         3'b101:  w_cond = ($signed(br_a) >= $signed(br_b));
         3'b110:  w_cond = (br_a <  br_b);
         3'b111:  w_cond = (br_a >= br_b);
         default: w_cond = 1'b0;
      endcase
   end

   // PC load qualification: any load request whose target is misaligned is dropped.
   always_comb begin
      w_take    = br_en & w_cond;
      w_ld      = pc_write | w_take;
      w_bad_tgt = (ALIGN_CHECK != 0) && (pc_in[1:0] != 2'b00);
      w_ld_ok   = w_ld & ~w_bad_tgt;
   end

   // Next-state logic for the fetch handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ack_take  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fetch_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_ack) begin
               w_ack_take  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register; reset drops the request immediately because req is decoded from state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Fetch address is latched at accept so a same-cycle PC load cannot move it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_addr <= '0;
      else if (w_accept) r_addr <= r_pc[31:0];
   end

   // Instruction register and its valid flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
      end else if (w_accept) begin
         r_ir_valid <= 1'b0;
      end else if (w_ack_take) begin
         r_ir       <= imem_rdata;
         r_ir_valid <= 1'b1;
      end
   end

   // PC update: direct in IDLE, deferred through the pending slot while a fetch
   // is outstanding, and applied on the ack edge (a same-cycle load wins).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (w_ld_ok) r_pc <= pc_in;
      end else if (w_ack_take) begin
         if (w_ld_ok)       r_pc <= pc_in;
         else if (r_pend_v) r_pc <= r_pend;
         r_pend_v <= 1'b0;
      end else if (w_ld_ok) begin
         r_pend   <= pc_in;
         r_pend_v <= 1'b1;
      end
   end

   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_misalign <= 1'b0;
      else if (w_ld && w_bad_tgt) r_misalign <= 1'b1;
   end

   assign imem_req  = (r_state == ST_WAIT);
   assign busy      = (r_state == ST_WAIT);
   assign imem_addr = (r_state == ST_WAIT) ? r_addr : r_pc[31:0];
   assign ir        = r_ir;
   assign ir_valid  = r_ir_valid;
   assign pc        = r_pc;
   assign misalign  = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: drives inputs on the falling edge and
// checks outputs on the following falling edge.
module tb_pc_fetch_unit;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            fetch_start;
   logic            imem_req;
   logic [31:0]     imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic [31:0]     ir;
   logic            ir_valid;
   logic            busy;
   logic [XLEN-1:0] pc;
   logic            pc_write;
   logic            br_en;
   logic [2:0]      br_cond;
   logic [XLEN-1:0] br_a;
   logic [XLEN-1:0] br_b;
   logic [XLEN-1:0] pc_in;
   logic            misalign;

   int n_tests = 0;
   int n_fail  = 0;

   pc_fetch_unit #(.XLEN(XLEN), .RESET_PC('0), .ALIGN_CHECK(1)) dut (
      .clk(clk), .reset(reset), .fetch_start(fetch_start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .busy(busy),
      .pc(pc), .pc_write(pc_write), .br_en(br_en), .br_cond(br_cond),
      .br_a(br_a), .br_b(br_b), .pc_in(pc_in), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [2:0] conds [8];
   logic       takes [8];

   initial begin
      conds = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
      takes = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};

      reset = 1'b1; fetch_start = 0; imem_ack = 0; imem_rdata = '0;
      pc_write = 0; br_en = 0; br_cond = '0; br_a = '0; br_b = '0; pc_in = '0;
      step(); step();
      chk("rst_pc", pc, 64'h0);
      chk("rst_ir", {32'h0, ir}, 64'h0);
      chk("rst_irv", {63'h0, ir_valid}, 64'h0);
      chk("rst_req", {63'h0, imem_req}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_mis", {63'h0, misalign}, 64'h0);
      reset = 1'b0;
      step();

      // Fetch at pc=0, three WAIT cycles, ack in the third
      fetch_start = 1;
      step();
      fetch_start = 0;
      for (int c = 0; c < 3; c++) begin
         chk("f_req", {63'h0, imem_req}, 64'h1);
         chk("f_addr", {32'h0, imem_addr}, 64'h0);
         chk("f_busy", {63'h0, busy}, 64'h1);
         if (c == 2) begin imem_ack = 1; imem_rdata = 32'h0050_0093; end
         step();
      end
      imem_ack = 0; imem_rdata = '0;
      chk("f_ir", {32'h0, ir}, 64'h0050_0093);
      chk("f_irv", {63'h0, ir_valid}, 64'h1);
      chk("f_busy0", {63'h0, busy}, 64'h0);
      chk("f_req0", {63'h0, imem_req}, 64'h0);

      // ack in IDLE is ignored
      imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
      step();
      imem_ack = 0; imem_rdata = '0;
      chk("idle_ack_ir", {32'h0, ir}, 64'h0050_0093);
      chk("idle_ack_busy", {63'h0, busy}, 64'h0);

      // Branch condition sweep: a=-1, b=1
      br_a = '1; br_b = 64'd1;
      for (int i = 0; i < 8; i++) begin
         pc_write = 1; pc_in = 64'h0;
         step();
         pc_write = 0; br_en = 1; br_cond = conds[i]; pc_in = 64'h40;
         step();
         br_en = 0;
         chk($sformatf("br_%03b", conds[i]), pc, takes[i] ? 64'h40 : 64'h0);
      end
      // br_en low masks a true condition
      br_en = 0; br_cond = 3'b001; pc_in = 64'h40;
      step();
      chk("br_en0", pc, 64'h0);

      // Deferred PC writes during WAIT, last wins
      pc_write = 1; pc_in = 64'h20;
      step();
      pc_write = 0; fetch_start = 1;
      step();
      fetch_start = 0;
      chk("d_irv0", {63'h0, ir_valid}, 64'h0);
      pc_write = 1; pc_in = 64'h80;
      step();
      chk("d_pc1", pc, 64'h20);
      chk("d_addr", {32'h0, imem_addr}, 64'h20);
      pc_in = 64'h90;
      step();
      pc_write = 0;
      chk("d_pc2", pc, 64'h20);
      imem_ack = 1; imem_rdata = 32'h1234_5678;
      step();
      imem_ack = 0;
      chk("d_pc3", pc, 64'h90);
      chk("d_ir", {32'h0, ir}, 64'h1234_5678);

      // Load and ack in the same WAIT cycle
      fetch_start = 1;
      step();
      fetch_start = 0; pc_write = 1; pc_in = 64'hA0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      step();
      pc_write = 0; imem_ack = 0;
      chk("la_pc", pc, 64'hA0);
      chk("la_ir", {32'h0, ir}, 64'hDEAD_BEEF);
      chk("la_irv", {63'h0, ir_valid}, 64'h1);

      // Misaligned target rejected, flag sticky
      pc_write = 1; pc_in = 64'h82;
      step();
      pc_write = 0;
      chk("m_pc", pc, 64'hA0);
      chk("m_flag", {63'h0, misalign}, 64'h1);
      pc_write = 1; pc_in = 64'hB0;
      step();
      pc_write = 0;
      chk("m_pc2", pc, 64'hB0);
      chk("m_flag2", {63'h0, misalign}, 64'h1);

      // fetch_start and pc_write together in IDLE
      pc_write = 1; pc_in = 64'h10;
      step();
      fetch_start = 1; pc_in = 64'h100;
      step();
      fetch_start = 0; pc_write = 0;
      chk("fs_addr", {32'h0, imem_addr}, 64'h10);
      chk("fs_pc", pc, 64'h100);
      chk("fs_busy", {63'h0, busy}, 64'h1);

      // Async reset mid-WAIT
      #1 reset = 1;
      #1;
      chk("ar_req", {63'h0, imem_req}, 64'h0);
      chk("ar_busy", {63'h0, busy}, 64'h0);
      chk("ar_pc", pc, 64'h0);
      chk("ar_irv", {63'h0, ir_valid}, 64'h0);
      chk("ar_mis", {63'h0, misalign}, 64'h0);
      step();
      reset = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
